// File: rtl/date_carousel.sv
// Purpose: sequences a table of six-digit dates onto HEX5..HEX0, stepping on a debounced key or a timer.
// Latency: switch->leds 3 cycles; raw key edge->press 2+DEBOUNCE_CYCLES; press->idx/invert 1; idx/invert->outputs 1.
// Backpressure: none; every input is sampled each cycle and every output is a free-running register.
module date_carousel #(
  parameter int                    NUM_DATES       = 4,
  parameter logic [24*NUM_DATES-1:0] DATES         = {24'h010823, 24'h010824, 24'h123199, 24'h000000},
  parameter int                    DEBOUNCE_CYCLES = 500000,
  parameter int                    ROTATE_CYCLES   = 50000000,
  parameter bit                    DP_SEP          = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [9:0] switch,
  input  logic [1:0] key,
  output logic [9:0] leds,
  output logic [7:0] hex0,
  output logic [7:0] hex1,
  output logic [7:0] hex2,
  output logic [7:0] hex3,
  output logic [7:0] hex4,
  output logic [7:0] hex5
);

  localparam int IDX_W = (NUM_DATES > 1) ? $clog2(NUM_DATES) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam int TMR_W = $clog2(ROTATE_CYCLES);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DATES - 1);
  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TMR_W-1:0] ROT_LAST = TMR_W'(ROTATE_CYCLES - 1);

  // separator dots are active-low, so a lit dp is a 0
  localparam logic DP_MID = ~DP_SEP;

  logic [9:0]            sw_s1, sw_s2;
  logic [1:0]            key_s1, key_s2;
  logic [1:0]            key_d;
  logic [1:0][CNT_W-1:0] key_cnt;
  logic [1:0]            press;
  logic [TMR_W-1:0]      timer;
  logic [IDX_W-1:0]      idx;
  logic                  invert;
  logic                  adv_tog;
  logic                  expire;
  logic                  adv;
  logic [23:0]           cur;
  logic                  unused_sw8;

  // switch[8] is carried through the synchroniser but drives nothing
  assign unused_sw8 = sw_s2[8];

  // active-low segment glyphs {g,f,e,d,c,b,a}; non-decimal nibbles blank
  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  // two-flop synchronisers; keys idle high so they reset to 1
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sw_s1  <= '0;
      sw_s2  <= '0;
      key_s1 <= 2'b11;
      key_s2 <= 2'b11;
    end else begin
      sw_s1  <= switch;
      sw_s2  <= sw_s1;
      key_s1 <= key;
      key_s2 <= key_s1;
    end
  end

  // per-key debounce; press fires once when the accepted level falls 1->0
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_d   <= 2'b11;
      key_cnt <= '0;
      press   <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        press[i] <= 1'b0;
        if (key_s2[i] == key_d[i]) begin
          key_cnt[i] <= '0;
        end else if (key_cnt[i] == DB_LAST) begin
          key_d[i]   <= key_s2[i];
          key_cnt[i] <= '0;
          // new level is the complement of the old one, so old==1 means a press
          press[i]   <= key_d[i];
        end else begin
          key_cnt[i] <= key_cnt[i] + 1'b1;
        end
      end
    end
  end

  // a key press and a timer expiry on the same cycle merge into one advance
  assign expire = sw_s2[9] && (timer == ROT_LAST);
  assign adv    = press[1] | expire;

  // rotate timer, table index, invert flag and the advance toggle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer   <= '0;
      idx     <= '0;
      invert  <= 1'b0;
      adv_tog <= 1'b0;
    end else begin
      if (!sw_s2[9] || adv) timer <= '0;
      else                  timer <= timer + 1'b1;
      if (adv) begin
        idx     <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        adv_tog <= ~adv_tog;
      end
      if (press[0]) invert <= ~invert;
    end
  end

  // select the current table entry without a variable-width part-select
  always_comb begin
    cur = '0;
    for (int i = 0; i < NUM_DATES; i++) begin
      if (idx == IDX_W'(i)) cur = DATES[24*i +: 24];
    end
  end

  // registered display and LED drive
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      leds <= '0;
      hex0 <= 8'hFF;
      hex1 <= 8'hFF;
      hex2 <= 8'hFF;
      hex3 <= 8'hFF;
      hex4 <= 8'hFF;
      hex5 <= 8'hFF;
    end else begin
      leds <= {sw_s2[9], adv_tog, sw_s2[7:0] ^ {8{invert}}};
      hex0 <= {1'b1,   seg7(cur[3:0])};
      hex1 <= {1'b1,   seg7(cur[7:4])};
      hex2 <= {DP_MID, seg7(cur[11:8])};
      hex3 <= {1'b1,   seg7(cur[15:12])};
      hex4 <= {DP_MID, seg7(cur[19:16])};
      hex5 <= {1'b1,   seg7(cur[23:20])};
    end
  end

endmodule

// File: tb/tb_date_carousel.sv
// Purpose: directed check of date_carousel with a short debounce and rotate period.
// Latency: inputs change and outputs are sampled on the falling clock edge.
// Backpressure: none.
module tb_date_carousel;

  localparam int          NDATES = 3;
  localparam int          DB     = 4;
  localparam int          ROT    = 10;
  localparam logic [71:0] TB_DATES = {24'h5C7406, 24'h123199, 24'h010823};

  logic       clk = 1'b0;
  logic       reset_n;
  logic [9:0] switch;
  logic [1:0] key;
  logic [9:0] leds;
  logic [7:0] hex0, hex1, hex2, hex3, hex4, hex5;
  logic [47:0] hexall;

  int tests = 0;
  int fails = 0;
  int  idx_m;
  logic tog_m, inv_m;

  date_carousel #(
    .NUM_DATES       (NDATES),
    .DATES           (TB_DATES),
    .DEBOUNCE_CYCLES (DB),
    .ROTATE_CYCLES   (ROT),
    .DP_SEP          (1'b1)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .switch  (switch),
    .key     (key),
    .leds    (leds),
    .hex0    (hex0),
    .hex1    (hex1),
    .hex2    (hex2),
    .hex3    (hex3),
    .hex4    (hex4),
    .hex5    (hex5)
  );

  always #5 clk = ~clk;

  assign hexall = {hex5, hex4, hex3, hex2, hex1, hex0};

  // active-low glyphs {g,f,e,d,c,b,a}, written out by hand
  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'd0:    glyph = 7'b1000000;
      4'd1:    glyph = 7'b1111001;
      4'd2:    glyph = 7'b0100100;
      4'd3:    glyph = 7'b0110000;
      4'd4:    glyph = 7'b0011001;
      4'd5:    glyph = 7'b0010010;
      4'd6:    glyph = 7'b0000010;
      4'd7:    glyph = 7'b1111000;
      4'd8:    glyph = 7'b0000000;
      4'd9:    glyph = 7'b0010000;
      default: glyph = 7'b1111111;
    endcase
  endfunction

  function automatic logic [47:0] exp_disp(input int i);
    logic [71:0] t;
    logic [23:0] e;
    logic [47:0] r;
    t = TB_DATES;
    e = t[24*i +: 24];
    r = '0;
    for (int k = 0; k < 6; k++) begin
      r[8*k +: 8] = {((k == 2) || (k == 4)) ? 1'b0 : 1'b1, glyph(e[4*k +: 4])};
    end
    return r;
  endfunction

  function automatic logic [9:0] exp_leds(input logic sw9);
    return {sw9, tog_m, 8'hA5 ^ {8{inv_m}}};
  endfunction

  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic advance_model();
    idx_m = (idx_m == NDATES - 1) ? 0 : idx_m + 1;
    tog_m = ~tog_m;
  endtask

  // one clean key[1] press followed by a long release
  task automatic press_next(input string tag);
    key = 2'b01;
    tick(8);
    key = 2'b11;
    tick(12);
    advance_model();
    check({tag, "_hex"}, hexall, exp_disp(idx_m));
    check({tag, "_leds"}, {38'b0, leds}, {38'b0, exp_leds(1'b0)});
  endtask

  initial begin
    idx_m   = 0;
    tog_m   = 1'b0;
    inv_m   = 1'b0;
    reset_n = 1'b0;
    switch  = 10'h0A5;
    key     = 2'b11;

    // 1: reset state, release, first display load and switch latency
    tick(3);
    check("rst_leds", {38'b0, leds}, 48'h0);
    check("rst_hex", hexall, 48'hFFFF_FFFF_FFFF);
    reset_n = 1'b1;
    tick(1);
    check("first_hex", hexall, exp_disp(0));
    check("leds_e1", {38'b0, leds}, 48'h0);
    tick(1);
    check("leds_e2", {38'b0, leds}, 48'h0);
    tick(1);
    check("leds_e3", {38'b0, leds}, 48'h0A5);

    // 2: short glitch ignored, then invert toggles per press
    key = 2'b10;
    tick(3);
    key = 2'b11;
    tick(10);
    check("glitch", {38'b0, leds}, 48'h0A5);
    key = 2'b10;
    tick(7);
    check("inv_pre", {38'b0, leds}, 48'h0A5);
    tick(1);
    inv_m = 1'b1;
    check("inv_on", {38'b0, leds}, {38'b0, exp_leds(1'b0)});
    tick(10);
    check("inv_hold", {38'b0, leds}, 48'h05A);
    key = 2'b11;
    tick(10);
    check("inv_release", {38'b0, leds}, 48'h05A);
    key = 2'b10;
    tick(8);
    key = 2'b11;
    tick(10);
    inv_m = 1'b0;
    check("inv_off", {38'b0, leds}, 48'h0A5);

    // 3: key[1] presses step 0->1->2->0; first press timed exactly
    key = 2'b01;
    tick(7);
    check("adv_pre", hexall, exp_disp(0));
    tick(1);
    check("adv_hex1", hexall, exp_disp(1));
    key = 2'b11;
    tick(12);
    advance_model();
    check("adv1_leds", {38'b0, leds}, {38'b0, exp_leds(1'b0)});
    press_next("adv2");
    check("blank_c", {40'b0, hex4}, 48'h7F);
    press_next("adv3");

    // 4: auto rotate every ROT cycles, then hold when disabled
    switch = 10'h2A5;
    tick(3);
    check("rot_led9", {38'b0, leds}, {38'b0, exp_leds(1'b1)});
    tick(9);
    check("rot_pre", hexall, exp_disp(idx_m));
    tick(1);
    advance_model();
    check("rot_a1", hexall, exp_disp(idx_m));
    tick(9);
    check("rot_mid", hexall, exp_disp(idx_m));
    tick(1);
    advance_model();
    check("rot_a2", hexall, exp_disp(idx_m));
    switch = 10'h0A5;
    tick(30);
    check("rot_held", hexall, exp_disp(idx_m));
    check("rot_off_leds", {38'b0, leds}, {38'b0, exp_leds(1'b0)});

    // 5: key press lands on terminal count -> single advance, period restarts
    switch = 10'h2A5;
    tick(5);
    key = 2'b01;
    tick(7);
    check("coll_pre", hexall, exp_disp(idx_m));
    tick(1);
    advance_model();
    check("coll_one", hexall, exp_disp(idx_m));
    key = 2'b11;
    tick(9);
    check("coll_gap", hexall, exp_disp(idx_m));
    tick(1);
    advance_model();
    check("coll_next", hexall, exp_disp(idx_m));
    switch = 10'h0A5;
    tick(20);
    check("coll_leds", {38'b0, leds}, {38'b0, exp_leds(1'b0)});

    // 6: reset in the middle of a debounce leaves no event behind
    key = 2'b01;
    tick(4);
    reset_n = 1'b0;
    key = 2'b11;
    tick(1);
    check("mid_rst_hex", hexall, 48'hFFFF_FFFF_FFFF);
    check("mid_rst_leds", {38'b0, leds}, 48'h0);
    tick(2);
    reset_n = 1'b1;
    idx_m = 0;
    tog_m = 1'b0;
    inv_m = 1'b0;
    tick(15);
    check("post_rst_hex", hexall, exp_disp(0));
    check("post_rst_leds", {38'b0, leds}, {38'b0, exp_leds(1'b0)});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
